game_sequencer: RTL

- Central FSM for the two-player Halli Galli game.
- Accepts decoded keypad events and sequences the card datapath: draw enable, turn toggle, card count and table clear.
- Arbitrates bell presses between the two players, applies score updates and declares game over and the winner.
- Sits between keypad_scan and the rand_gen/card_value/score datapath, replacing scattered per-block enables.

---
 rtl/game_sequencer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: central FSM of the two-player Halli Galli game (draw, turn, bell, score, game over).
// Optional macro TURN_TIMEOUT_EN: auto-draw for the current player after TIMEOUT_CYC idle cycles in FLIP.
module game_sequencer #(
  parameter int MAX_CARDS   = 40,
  parameter int SCORE_W     = 8,
  parameter int WIN_SCORE   = 10,
  parameter int MATCH_LAT   = 2,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [3:0]         key_code,
  input  logic               match_in,
  output logic               draw_en,
  output logic               whose,
  output logic               table_clr,
  output logic [5:0]         card_cnt,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLIP  = 3'd1;
  localparam logic [2:0] S_WAITM = 3'd2;
  localparam logic [2:0] S_BELL  = 3'd3;
  localparam logic [2:0] S_SCORE = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam logic [3:0] K_START   = 4'd0;
  localparam logic [3:0] K_P1_FLIP = 4'd1;
  localparam logic [3:0] K_P1_BELL = 4'd2;
  localparam logic [3:0] K_P2_FLIP = 4'd3;
  localparam logic [3:0] K_P2_BELL = 4'd4;

  localparam int                 WAIT_W    = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MATCH_LAT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_ONE  = WAIT_W'(1);
  localparam logic [5:0]         MAX_CNT   = 6'(MAX_CARDS);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_MIN = {SCORE_W{1'b0}};
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + SCORE_ONE;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MIN) ? v : v - SCORE_ONE;
  endfunction

  function automatic logic [1:0] win_code(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    if (a > b) begin
      return 2'b01;
    end else if (a < b) begin
      return 2'b10;
    end else begin
      return 2'b11;
    end
  endfunction

  logic [2:0]         state_r, state_nxt;
  logic [WAIT_W-1:0]  wait_r, wait_nxt;
  logic               bell_p2_r, bell_p2_nxt;
  logic               whose_r, whose_nxt;
  logic [5:0]         card_cnt_r, card_cnt_nxt;
  logic [SCORE_W-1:0] score_a_r, score_a_nxt;
  logic [SCORE_W-1:0] score_b_r, score_b_nxt;
  logic               draw_r, draw_nxt;
  logic               clr_r, clr_nxt;
  logic               over_r, over_nxt;
  logic [1:0]         winner_r, winner_nxt;

  logic key_start_s, flip_own_s, bell_p1_s, bell_p2_s;
  logic bell_go_s, flip_go_s, tmo_s;

  // Key decode; the timeout only stands in for a flip when no real key was taken this cycle.
  always_comb begin
    key_start_s = key_valid && (key_code == K_START);
    bell_p1_s   = key_valid && (key_code == K_P1_BELL);
    bell_p2_s   = key_valid && (key_code == K_P2_BELL);
    if (whose_r) begin
      flip_own_s = key_valid && (key_code == K_P2_FLIP);
    end else begin
      flip_own_s = key_valid && (key_code == K_P1_FLIP);
    end
    bell_go_s = (state_r == S_FLIP) && (bell_p1_s || bell_p2_s) && (card_cnt_r != 6'd0);
    flip_go_s = (state_r == S_FLIP) && (flip_own_s || (tmo_s && !bell_go_s));
  end

`ifdef TURN_TIMEOUT_EN
  localparam int              TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  logic [TMO_W-1:0] tmo_cnt_r;

  assign tmo_s = (state_r == S_FLIP) && (tmo_cnt_r == TMO_LAST);

  // Idle timer: runs only in FLIP, restarts on any accepted key or on firing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if ((state_r != S_FLIP) || flip_own_s || bell_go_s || tmo_s) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
    end
  end
`else
  // Timeout disabled: constant false, TIMEOUT_CYC is always positive.
  assign tmo_s = (TIMEOUT_CYC < 0);
`endif

  // Next-state and next-value computation for every registered output.
  always_comb begin
    state_nxt    = state_r;
    wait_nxt     = wait_r;
    bell_p2_nxt  = bell_p2_r;
    whose_nxt    = whose_r;
    card_cnt_nxt = card_cnt_r;
    score_a_nxt  = score_a_r;
    score_b_nxt  = score_b_r;
    draw_nxt     = 1'b0;
    clr_nxt      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (key_start_s) begin
          state_nxt = S_FLIP;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_FLIP: begin
        if (flip_go_s) begin
          // The deck-exhausted check happens on the flip attempt, so bells stay legal until then.
          if (card_cnt_r == MAX_CNT) begin
            state_nxt = S_OVER;
          end else begin
            draw_nxt     = 1'b1;
            card_cnt_nxt = card_cnt_r + 6'd1;
            wait_nxt     = {WAIT_W{1'b0}};
            state_nxt    = S_WAITM;
          end
        end else if (bell_go_s) begin
          bell_p2_nxt = bell_p2_s;
          state_nxt   = S_BELL;
        end else begin
          state_nxt = S_FLIP;
        end
      end
      S_WAITM: begin
        if (wait_r == WAIT_LAST) begin
          whose_nxt = ~whose_r;
          state_nxt = S_FLIP;
        end else begin
          wait_nxt = wait_r + WAIT_ONE;
        end
      end
      S_BELL: begin
        if (bell_p2_r) begin
          score_b_nxt = match_in ? sat_inc(score_b_r) : sat_dec(score_b_r);
        end else begin
          score_a_nxt = match_in ? sat_inc(score_a_r) : sat_dec(score_a_r);
        end
        whose_nxt = bell_p2_r;
        clr_nxt   = 1'b1;
        state_nxt = S_SCORE;
      end
      S_SCORE: begin
        if ((score_a_r == WIN_VAL) || (score_b_r == WIN_VAL)) begin
          state_nxt = S_OVER;
        end else if (card_cnt_r == MAX_CNT) begin
          state_nxt = S_OVER;
        end else begin
          state_nxt = S_FLIP;
        end
      end
      S_OVER: begin
        if (key_start_s) begin
          score_a_nxt  = SCORE_MIN;
          score_b_nxt  = SCORE_MIN;
          card_cnt_nxt = 6'd0;
          whose_nxt    = 1'b0;
          clr_nxt      = 1'b1;
          state_nxt    = S_FLIP;
        end else begin
          state_nxt = S_OVER;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    over_nxt   = (state_nxt == S_OVER);
    winner_nxt = (state_nxt == S_OVER) ? win_code(score_a_nxt, score_b_nxt) : 2'b00;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      wait_r     <= {WAIT_W{1'b0}};
      bell_p2_r  <= 1'b0;
      whose_r    <= 1'b0;
      card_cnt_r <= 6'd0;
      score_a_r  <= SCORE_MIN;
      score_b_r  <= SCORE_MIN;
      draw_r     <= 1'b0;
      clr_r      <= 1'b0;
      over_r     <= 1'b0;
      winner_r   <= 2'b00;
    end else begin
      state_r    <= state_nxt;
      wait_r     <= wait_nxt;
      bell_p2_r  <= bell_p2_nxt;
      whose_r    <= whose_nxt;
      card_cnt_r <= card_cnt_nxt;
      score_a_r  <= score_a_nxt;
      score_b_r  <= score_b_nxt;
      draw_r     <= draw_nxt;
      clr_r      <= clr_nxt;
      over_r     <= over_nxt;
      winner_r   <= winner_nxt;
    end
  end

  assign draw_en   = draw_r;
  assign whose     = whose_r;
  assign table_clr = clr_r;
  assign card_cnt  = card_cnt_r;
  assign score_a   = score_a_r;
  assign score_b   = score_b_r;
  assign game_over = over_r;
  assign winner    = winner_r;

endmodule
